// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: word geometry, opcode set,
// FSM state encoding and the opcode legality check.
package instr_encoder_pkg;

  localparam int DWIDTH = 32;
  localparam int RWIDTH = 6;
  localparam int IMM_IN = 15;

  localparam logic [DWIDTH-1:0] NOP_WORD = 32'h0007_8000;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0010,
    OP_AND = 4'b0011,
    OP_OR  = 4'b0100,
    OP_XOR = 4'b0110,
    OP_LD  = 4'b1000,
    OP_ST  = 4'b1001,
    OP_BEQ = 4'b1010,
    OP_BNE = 4'b1011,
    OP_JMP = 4'b1101,
    OP_NOP = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LD,
      OP_ST, OP_BEQ, OP_BNE, OP_JMP, OP_NOP: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Small word FIFO between the field handshake and the memory write port.
// Flush empties it synchronously; storage is left unreset so it can map to RAM.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{PW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction fields into 32-bit words and streams a session of them
// into instruction memory starting at base_addr, through a small FIFO.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int AWIDTH = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_imm_mode,
  input  logic [3:0]        in_op,
  input  logic [RWIDTH-1:0] in_rs,
  input  logic [RWIDTH-1:0] in_rd,
  input  logic [RWIDTH-1:0] in_rt,
  input  logic [IMM_IN-1:0] in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              done,
  output logic              busy,
  output logic              err_illegal
);

  localparam logic [AWIDTH:0] CNT_ONE = {{AWIDTH{1'b0}}, 1'b1};

  state_e            state;
  logic [AWIDTH-1:0] base_q;
  logic [AWIDTH:0]   count_q;
  logic [AWIDTH:0]   accepted;
  logic [AWIDTH:0]   written;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DWIDTH-1:0] fifo_head;
  logic [DWIDTH-1:0] enc_word;
  logic              op_legal;
  logic              push;
  logic              pop;
  logic              flush;

  assign op_legal = is_legal_op(in_op);

  // Register mode keeps only the low 9 immediate bits; rt is dropped in
  // immediate mode. Illegal opcodes turn the whole word into a NOP.
  always_comb begin
    enc_word        = '0;
    enc_word[31]    = in_imm_mode;
    enc_word[30:25] = in_rs;
    enc_word[24:19] = in_rd;
    enc_word[18:15] = in_op;
    if (in_imm_mode) begin
      enc_word[14:0] = in_imm;
    end else begin
      enc_word[14:9] = in_rt;
      enc_word[8:0]  = in_imm[8:0];
    end
    if (!op_legal) enc_word = NOP_WORD;
  end

  assign in_ready  = (state == ST_RUN) && !fifo_full && (accepted < count_q);
  assign push      = in_valid && in_ready;
  assign mem_we    = (state == ST_RUN) && !fifo_empty;
  assign pop       = mem_we && mem_ready;
  assign flush     = (state == ST_RUN) && abort;
  assign mem_addr  = base_q + written[AWIDTH-1:0];
  assign mem_wdata = mem_we ? fifo_head : '0;
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DWIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (enc_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // The RUN->DONE check uses the registered written count, so DONE follows
  // one cycle after the final write is acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      accepted    <= '0;
      written     <= '0;
      err_illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_illegal <= 1'b0;
            base_q      <= base_addr;
            count_q     <= count;
            accepted    <= '0;
            written     <= '0;
            state       <= (count == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            accepted <= '0;
            written  <= '0;
            state    <= ST_IDLE;
          end else begin
            if (push) begin
              accepted <= accepted + CNT_ONE;
              if (!op_legal) err_illegal <= 1'b1;
            end
            if (pop) written <= written + CNT_ONE;
            if (written == count_q) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
